mips_multicycle_ctrl: RTL and testbench

- Multi-cycle control FSM for the MIPS stub. It is the issuing end of the ALU interface.
- Drives the 4-bit ALU op_code and the datapath mux selects each cycle.
- Consumes the ALU zero/equal/overflow flags to resolve branches and arithmetic traps.
- Sequences FETCH→DECODE→EXECUTE→MEM→WB over a single-port memory using a ready handshake.

---
 rtl/mips_multicycle_ctrl_pkg.sv | 89 ++++++++
 rtl/mips_multicycle_ctrl_if.sv | 45 ++++
 rtl/mips_multicycle_ctrl_alu_funct_decode.sv | 28 ++
 rtl/mips_multicycle_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared encodings for the MIPS multi-cycle control FSM: states, mux selects,
// ALU op codes, opcode/funct constants and trap causes.
package mips_multicycle_ctrl_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned ALU_OP_W = 4;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned OPC_W = 6;
    localparam int unsigned FUNCT_W = 6;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_R_EXEC    = 4'd2,
        S_I_EXEC    = 4'd3,
        S_ALU_WB    = 4'd4,
        S_MEM_ADDR  = 4'd5,
        S_MEM_READ  = 4'd6,
        S_MEM_WB    = 4'd7,
        S_MEM_WRITE = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_TRAP      = 4'd11
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_OVERFLOW = 2'd1,
        CAUSE_ILLEGAL  = 2'd2,
        CAUSE_BUS      = 2'd3
    } cause_e;

    // ALU op codes shared with the ALU
    localparam logic [ALU_OP_W-1:0] OP_ADD = 4'h0;
    localparam logic [ALU_OP_W-1:0] OP_SUB = 4'h1;
    localparam logic [ALU_OP_W-1:0] OP_AND = 4'h2;
    localparam logic [ALU_OP_W-1:0] OP_OR  = 4'h3;
    localparam logic [ALU_OP_W-1:0] OP_XOR = 4'h4;
    localparam logic [ALU_OP_W-1:0] OP_NOR = 4'h5;
    localparam logic [ALU_OP_W-1:0] OP_SLT = 4'h6;
    localparam logic [ALU_OP_W-1:0] OP_SLL = 4'h7;
    localparam logic [ALU_OP_W-1:0] OP_SRL = 4'h8;
    localparam logic [ALU_OP_W-1:0] OP_SRA = 4'h9;

    // ALU operand and PC source selects
    localparam logic [SEL_W-1:0] SRCA_PC     = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_REG    = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_SHAMT  = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_REG    = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR   = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM    = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_BRANCH = 2'b11;
    localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [SEL_W-1:0] PCSRC_EXC    = 2'b11;

    // Opcodes
    localparam logic [OPC_W-1:0] OPC_RTYPE = 6'h00;
    localparam logic [OPC_W-1:0] OPC_J     = 6'h02;
    localparam logic [OPC_W-1:0] OPC_BEQ   = 6'h04;
    localparam logic [OPC_W-1:0] OPC_BNE   = 6'h05;
    localparam logic [OPC_W-1:0] OPC_ADDI  = 6'h08;
    localparam logic [OPC_W-1:0] OPC_ANDI  = 6'h0C;
    localparam logic [OPC_W-1:0] OPC_ORI   = 6'h0D;
    localparam logic [OPC_W-1:0] OPC_LW    = 6'h23;
    localparam logic [OPC_W-1:0] OPC_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [FUNCT_W-1:0] F_SLL = 6'h00;
    localparam logic [FUNCT_W-1:0] F_SRL = 6'h02;
    localparam logic [FUNCT_W-1:0] F_SRA = 6'h03;
    localparam logic [FUNCT_W-1:0] F_ADD = 6'h20;
    localparam logic [FUNCT_W-1:0] F_SUB = 6'h22;
    localparam logic [FUNCT_W-1:0] F_AND = 6'h24;
    localparam logic [FUNCT_W-1:0] F_OR  = 6'h25;
    localparam logic [FUNCT_W-1:0] F_XOR = 6'h26;
    localparam logic [FUNCT_W-1:0] F_NOR = 6'h27;
    localparam logic [FUNCT_W-1:0] F_SLT = 6'h2A;

    // Result of decoding an R-type funct field
    typedef struct packed {
        logic [ALU_OP_W-1:0] alu_op;
        logic                is_shift;
        logic                valid;
        logic                can_overflow;
    } funct_dec_t;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Control/datapath interface: controller drives selects and strobes, datapath
// returns instruction fields, ALU flags and the memory ready.
interface mips_multicycle_ctrl_if;
    import mips_multicycle_ctrl_pkg::*;

    logic [OPC_W-1:0]    opcode;
    logic [FUNCT_W-1:0]  funct;
    logic                alu_zero;
    logic                alu_equal;
    logic                alu_overflow;
    logic                mem_ready;
    logic [ALU_OP_W-1:0] alu_op;
    logic [SEL_W-1:0]    alu_src_a;
    logic [SEL_W-1:0]    alu_src_b;
    logic                imm_zext;
    logic                iord;
    logic                mem_read;
    logic                mem_write;
    logic                ir_write;
    logic                pc_write;
    logic [SEL_W-1:0]    pc_src;
    logic                reg_write;
    logic                reg_dst;
    logic                mem_to_reg;
    logic                epc_write;
    logic                exc_overflow;
    logic                exc_illegal;
    logic                exc_bus;
    logic [STATE_W-1:0]  state_dbg;

    modport master (
        input  opcode, funct, alu_zero, alu_equal, alu_overflow, mem_ready,
        output alu_op, alu_src_a, alu_src_b, imm_zext, iord, mem_read, mem_write,
               ir_write, pc_write, pc_src, reg_write, reg_dst, mem_to_reg,
               epc_write, exc_overflow, exc_illegal, exc_bus, state_dbg
    );

    modport slave (
        output opcode, funct, alu_zero, alu_equal, alu_overflow, mem_ready,
        input  alu_op, alu_src_a, alu_src_b, imm_zext, iord, mem_read, mem_write,
               ir_write, pc_write, pc_src, reg_write, reg_dst, mem_to_reg,
               epc_write, exc_overflow, exc_illegal, exc_bus, state_dbg
    );

endinterface

// File: rtl/mips_multicycle_ctrl_alu_funct_decode.sv
// Combinational R-type funct decoder: ALU op, shift flag, legality, overflow-capable.
module alu_funct_decode
    import mips_multicycle_ctrl_pkg::*;
(
    input  logic [FUNCT_W-1:0] funct,
    output funct_dec_t         dec_c
);

    // Map funct to ALU op; unknown codes are flagged invalid
    always_comb begin
        dec_c = '0;
        dec_c.valid = 1'b1;
        case (funct)
            F_ADD: begin dec_c.alu_op = OP_ADD; dec_c.can_overflow = 1'b1; end
            F_SUB: begin dec_c.alu_op = OP_SUB; dec_c.can_overflow = 1'b1; end
            F_AND: dec_c.alu_op = OP_AND;
            F_OR:  dec_c.alu_op = OP_OR;
            F_XOR: dec_c.alu_op = OP_XOR;
            F_NOR: dec_c.alu_op = OP_NOR;
            F_SLT: dec_c.alu_op = OP_SLT;
            F_SLL: begin dec_c.alu_op = OP_SLL; dec_c.is_shift = 1'b1; end
            F_SRL: begin dec_c.alu_op = OP_SRL; dec_c.is_shift = 1'b1; end
            F_SRA: begin dec_c.alu_op = OP_SRA; dec_c.is_shift = 1'b1; end
            default: dec_c.valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and raises overflow, illegal-instruction and bus-timeout traps.
module mips_multicycle_ctrl
    import mips_multicycle_ctrl_pkg::*;
#(
    parameter bit          TRAP_ON_OVERFLOW = 1'b1,
    parameter int unsigned MEM_TIMEOUT      = 0
)
(
    input  logic                  clk,
    input  logic                  rstb,
    mips_multicycle_ctrl_if.master bus
);

    localparam int unsigned CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_e           state, state_nxt;
    cause_e           cause, cause_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    funct_dec_t       fdec_c;
    logic             waiting_c;
    logic             expire_c;
    logic             unused_flags;

    // Branches compare through SUB and alu_equal; the zero flag carries no extra info
    assign unused_flags = bus.alu_zero;

    alu_funct_decode u_funct_decode (
        .funct (bus.funct),
        .dec_c (fdec_c)
    );

    // Memory wait tracking; ready in the expiring cycle takes priority
    always_comb begin
        waiting_c = ((state == S_FETCH) || (state == S_MEM_READ) || (state == S_MEM_WRITE))
                    && !bus.mem_ready;
        expire_c  = (MEM_TIMEOUT != 0) && waiting_c && (cnt == CNT_LAST);
    end

    // Next-state, trap cause and timeout counter
    always_comb begin
        state_nxt = state;
        cause_nxt = cause;
        cnt_nxt   = '0;
        if ((MEM_TIMEOUT != 0) && waiting_c && !expire_c) begin
            cnt_nxt = cnt + CNT_W'(1);
        end
        case (state)
            S_FETCH: begin
                if (bus.mem_ready) begin
                    state_nxt = S_DECODE;
                end else if (expire_c) begin
                    state_nxt = S_TRAP;
                    cause_nxt = CAUSE_BUS;
                end
            end
            S_DECODE: begin
                case (bus.opcode)
                    OPC_RTYPE:                   state_nxt = S_R_EXEC;
                    OPC_LW, OPC_SW:              state_nxt = S_MEM_ADDR;
                    OPC_BEQ, OPC_BNE:            state_nxt = S_BRANCH;
                    OPC_J:                       state_nxt = S_JUMP;
                    OPC_ADDI, OPC_ANDI, OPC_ORI: state_nxt = S_I_EXEC;
                    default: begin
                        state_nxt = S_TRAP;
                        cause_nxt = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_R_EXEC: begin
                if (!fdec_c.valid) begin
                    state_nxt = S_TRAP;
                    cause_nxt = CAUSE_ILLEGAL;
                end else if (TRAP_ON_OVERFLOW && fdec_c.can_overflow && bus.alu_overflow) begin
                    state_nxt = S_TRAP;
                    cause_nxt = CAUSE_OVERFLOW;
                end else begin
                    state_nxt = S_ALU_WB;
                end
            end
            S_I_EXEC: begin
                if (TRAP_ON_OVERFLOW && (bus.opcode == OPC_ADDI) && bus.alu_overflow) begin
                    state_nxt = S_TRAP;
                    cause_nxt = CAUSE_OVERFLOW;
                end else begin
                    state_nxt = S_ALU_WB;
                end
            end
            S_MEM_ADDR: state_nxt = (bus.opcode == OPC_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ: begin
                if (bus.mem_ready) begin
                    state_nxt = S_MEM_WB;
                end else if (expire_c) begin
                    state_nxt = S_TRAP;
                    cause_nxt = CAUSE_BUS;
                end
            end
            S_MEM_WRITE: begin
                if (bus.mem_ready) begin
                    state_nxt = S_FETCH;
                end else if (expire_c) begin
                    state_nxt = S_TRAP;
                    cause_nxt = CAUSE_BUS;
                end
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    // State, cause and counter registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state <= S_FETCH;
            cause <= CAUSE_NONE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cause <= cause_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign bus.state_dbg = state;

    // Datapath controls decoded from state, instruction fields and flags
    always_comb begin
        bus.alu_op       = OP_ADD;
        bus.alu_src_a    = SRCA_PC;
        bus.alu_src_b    = SRCB_REG;
        bus.imm_zext     = 1'b0;
        bus.iord         = 1'b0;
        bus.mem_read     = 1'b0;
        bus.mem_write    = 1'b0;
        bus.ir_write     = 1'b0;
        bus.pc_write     = 1'b0;
        bus.pc_src       = PCSRC_ALU;
        bus.reg_write    = 1'b0;
        bus.reg_dst      = 1'b0;
        bus.mem_to_reg   = 1'b0;
        bus.epc_write    = 1'b0;
        bus.exc_overflow = 1'b0;
        bus.exc_illegal  = 1'b0;
        bus.exc_bus      = 1'b0;
        case (state)
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = SRCB_FOUR;
                if (bus.mem_ready) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                end
            end
            S_DECODE: bus.alu_src_b = SRCB_BRANCH;
            S_R_EXEC: begin
                bus.alu_op    = fdec_c.alu_op;
                bus.alu_src_a = fdec_c.is_shift ? SRCA_SHAMT : SRCA_REG;
            end
            S_I_EXEC: begin
                bus.alu_src_a = SRCA_REG;
                bus.alu_src_b = SRCB_IMM;
                if (bus.opcode == OPC_ANDI) begin
                    bus.alu_op   = OP_AND;
                    bus.imm_zext = 1'b1;
                end else if (bus.opcode == OPC_ORI) begin
                    bus.alu_op   = OP_OR;
                    bus.imm_zext = 1'b1;
                end
            end
            S_ALU_WB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = (bus.opcode == OPC_RTYPE);
            end
            S_MEM_ADDR: begin
                bus.alu_src_a = SRCA_REG;
                bus.alu_src_b = SRCB_IMM;
            end
            S_MEM_READ: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
            end
            S_MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                bus.mem_write = 1'b1;
                bus.iord      = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a = SRCA_REG;
                bus.alu_op    = OP_SUB;
                bus.pc_src    = PCSRC_ALUOUT;
                bus.pc_write  = (bus.opcode == OPC_BEQ) ? bus.alu_equal : !bus.alu_equal;
            end
            S_JUMP: begin
                bus.pc_write = 1'b1;
                bus.pc_src   = PCSRC_JUMP;
            end
            S_TRAP: begin
                bus.epc_write    = 1'b1;
                bus.pc_write     = 1'b1;
                bus.pc_src       = PCSRC_EXC;
                bus.exc_overflow = (cause == CAUSE_OVERFLOW);
                bus.exc_illegal  = (cause == CAUSE_ILLEGAL);
                bus.exc_bus      = (cause == CAUSE_BUS);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for the MIPS multi-cycle control FSM. Instance a traps on
// overflow with no memory timeout; instance b ignores overflow and times out
// after 4 wait cycles. Both see the same inputs.
module tb_mips_multicycle_ctrl;
    import mips_multicycle_ctrl_pkg::*;

    logic clk;
    logic rstb;
    int   n_tests = 0;
    int   n_fail  = 0;

    mips_multicycle_ctrl_if bus_a ();
    mips_multicycle_ctrl_if bus_b ();

    assign bus_b.opcode       = bus_a.opcode;
    assign bus_b.funct        = bus_a.funct;
    assign bus_b.alu_zero     = bus_a.alu_zero;
    assign bus_b.alu_equal    = bus_a.alu_equal;
    assign bus_b.alu_overflow = bus_a.alu_overflow;
    assign bus_b.mem_ready    = bus_a.mem_ready;

    mips_multicycle_ctrl #(.TRAP_ON_OVERFLOW(1'b1), .MEM_TIMEOUT(0)) dut_a (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus_a)
    );

    mips_multicycle_ctrl #(.TRAP_ON_OVERFLOW(1'b0), .MEM_TIMEOUT(4)) dut_b (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Set mem_ready for the current cycle and let combinational outputs settle
    task automatic cyc(input logic mr);
        bus_a.mem_ready = mr;
        #1;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [5:0] opc, input logic [5:0] fn);
        rstb = 1'b0;
        bus_a.opcode = opc;
        bus_a.funct = fn;
        bus_a.alu_zero = 1'b0;
        bus_a.alu_equal = 1'b0;
        bus_a.alu_overflow = 1'b0;
        bus_a.mem_ready = 1'b0;
        adv();
        adv();
        rstb = 1'b1;
    endtask

    initial begin
        // add with three FETCH wait cycles
        do_reset(OPC_RTYPE, F_ADD);
        cyc(1'b0);
        check("rst_state", bus_a.state_dbg, S_FETCH);
        check("rst_mem_read", bus_a.mem_read, 1);
        check("rst_ir_write", bus_a.ir_write, 0);
        check("rst_reg_write", bus_a.reg_write, 0);
        check("fetch_srcb", bus_a.alu_src_b, SRCB_FOUR);
        check("fetch_op", bus_a.alu_op, OP_ADD);
        adv(); cyc(1'b0); check("add_wait2", bus_a.state_dbg, S_FETCH);
        adv(); cyc(1'b0); check("add_wait3", bus_a.state_dbg, S_FETCH);
        adv(); cyc(1'b1);
        check("add_ready_state", bus_a.state_dbg, S_FETCH);
        check("add_ir_write", bus_a.ir_write, 1);
        check("add_pc_write", bus_a.pc_write, 1);
        check("add_pc_src", bus_a.pc_src, PCSRC_ALU);
        adv(); cyc(1'b0);
        check("add_decode", bus_a.state_dbg, S_DECODE);
        check("add_decode_srcb", bus_a.alu_src_b, SRCB_BRANCH);
        check("b_ready_beats_expire", bus_b.state_dbg, S_DECODE);
        adv(); cyc(1'b0);
        check("add_rexec", bus_a.state_dbg, S_R_EXEC);
        check("add_alu_op", bus_a.alu_op, OP_ADD);
        check("add_srca", bus_a.alu_src_a, SRCA_REG);
        adv(); cyc(1'b0);
        check("add_wb", bus_a.state_dbg, S_ALU_WB);
        check("add_reg_write", bus_a.reg_write, 1);
        check("add_reg_dst", bus_a.reg_dst, 1);
        check("add_mem_to_reg", bus_a.mem_to_reg, 0);
        adv(); cyc(1'b0);
        check("add_back_fetch", bus_a.state_dbg, S_FETCH);

        // lw with immediate memory
        do_reset(OPC_LW, 6'h00);
        cyc(1'b1); check("lw_s0", bus_a.state_dbg, S_FETCH);
        adv(); cyc(1'b1); check("lw_s1", bus_a.state_dbg, S_DECODE);
        adv(); cyc(1'b1); check("lw_s2", bus_a.state_dbg, S_MEM_ADDR);
        check("lw_addr_srcb", bus_a.alu_src_b, SRCB_IMM);
        adv(); cyc(1'b1); check("lw_s3", bus_a.state_dbg, S_MEM_READ);
        check("lw_iord", bus_a.iord, 1);
        check("lw_mem_read", bus_a.mem_read, 1);
        adv(); cyc(1'b1); check("lw_s4", bus_a.state_dbg, S_MEM_WB);
        check("lw_mem_to_reg", bus_a.mem_to_reg, 1);
        check("lw_reg_write", bus_a.reg_write, 1);
        check("lw_reg_dst", bus_a.reg_dst, 0);

        // beq taken, then bne with equal operands
        do_reset(OPC_BEQ, 6'h00);
        bus_a.alu_equal = 1'b1;
        cyc(1'b1); adv(); cyc(1'b1); adv(); cyc(1'b1);
        check("beq_state", bus_a.state_dbg, S_BRANCH);
        check("beq_pc_write", bus_a.pc_write, 1);
        check("beq_pc_src", bus_a.pc_src, PCSRC_ALUOUT);
        check("beq_alu_op", bus_a.alu_op, OP_SUB);
        adv(); bus_a.opcode = OPC_BNE;
        cyc(1'b1); adv(); cyc(1'b1); adv(); cyc(1'b1);
        check("bne_state", bus_a.state_dbg, S_BRANCH);
        check("bne_eq_pc_write", bus_a.pc_write, 0);
        bus_a.alu_equal = 1'b0; #1;
        check("bne_ne_pc_write", bus_a.pc_write, 1);

        // addi overflow: a traps, b writes back
        do_reset(OPC_ADDI, 6'h00);
        cyc(1'b1); adv(); cyc(1'b1); adv(); cyc(1'b1);
        bus_a.alu_overflow = 1'b1; #1;
        check("addi_iexec", bus_a.state_dbg, S_I_EXEC);
        check("addi_zext", bus_a.imm_zext, 0);
        adv(); bus_a.alu_overflow = 1'b0; cyc(1'b1);
        check("ovf_trap", bus_a.state_dbg, S_TRAP);
        check("ovf_exc", bus_a.exc_overflow, 1);
        check("ovf_epc", bus_a.epc_write, 1);
        check("ovf_pc_src", bus_a.pc_src, PCSRC_EXC);
        check("ovf_no_reg_write", bus_a.reg_write, 0);
        check("b_ovf_wb", bus_b.state_dbg, S_ALU_WB);
        check("b_ovf_reg_write", bus_b.reg_write, 1);
        adv(); cyc(1'b1);
        check("ovf_back_fetch", bus_a.state_dbg, S_FETCH);
        check("ovf_pulse_end", bus_a.exc_overflow, 0);
        check("ovf_epc_end", bus_a.epc_write, 0);

        // andi zero-extends, shift uses shamt
        do_reset(OPC_ANDI, 6'h00);
        cyc(1'b1); adv(); cyc(1'b1); adv(); cyc(1'b1);
        check("andi_op", bus_a.alu_op, OP_AND);
        check("andi_zext", bus_a.imm_zext, 1);
        adv(); cyc(1'b1);
        check("andi_reg_dst", bus_a.reg_dst, 0);
        do_reset(OPC_RTYPE, F_SLL);
        cyc(1'b1); adv(); cyc(1'b1); adv(); cyc(1'b1);
        check("sll_op", bus_a.alu_op, OP_SLL);
        check("sll_srca", bus_a.alu_src_a, SRCA_SHAMT);

        // jump
        do_reset(OPC_J, 6'h00);
        cyc(1'b1); adv(); cyc(1'b1); adv(); cyc(1'b1);
        check("j_state", bus_a.state_dbg, S_JUMP);
        check("j_pc_src", bus_a.pc_src, PCSRC_JUMP);
        check("j_pc_write", bus_a.pc_write, 1);

        // illegal opcode
        do_reset(6'h3F, 6'h00);
        cyc(1'b1); adv(); cyc(1'b1); adv(); cyc(1'b1);
        check("illop_exc", bus_a.exc_illegal, 1);
        check("illop_state", bus_a.state_dbg, S_TRAP);
        adv(); cyc(1'b1);
        check("illop_end", bus_a.exc_illegal, 0);
        check("illop_fetch", bus_a.state_dbg, S_FETCH);

        // illegal funct
        do_reset(OPC_RTYPE, 6'h3F);
        cyc(1'b1); adv(); cyc(1'b1); adv(); cyc(1'b1);
        check("illfn_rexec", bus_a.state_dbg, S_R_EXEC);
        adv(); cyc(1'b1);
        check("illfn_exc", bus_a.exc_illegal, 1);
        check("illfn_no_ovf", bus_a.exc_overflow, 0);
        adv(); cyc(1'b1);
        check("illfn_fetch", bus_a.state_dbg, S_FETCH);

        // fetch timeout on b after four wait cycles; a keeps waiting
        do_reset(OPC_RTYPE, F_ADD);
        cyc(1'b0); adv(); cyc(1'b0); adv(); cyc(1'b0); adv(); cyc(1'b0);
        check("to_wait4", bus_b.state_dbg, S_FETCH);
        check("to_no_exc_yet", bus_b.exc_bus, 0);
        adv(); cyc(1'b0);
        check("to_trap", bus_b.state_dbg, S_TRAP);
        check("to_exc_bus", bus_b.exc_bus, 1);
        check("to_a_waits", bus_a.state_dbg, S_FETCH);
        adv(); cyc(1'b0);
        check("to_exc_end", bus_b.exc_bus, 0);

        // reset during MEM_WRITE
        do_reset(OPC_SW, 6'h00);
        cyc(1'b1); adv(); cyc(1'b1); adv(); cyc(1'b1); adv(); cyc(1'b0);
        check("sw_state", bus_a.state_dbg, S_MEM_WRITE);
        check("sw_mem_write", bus_a.mem_write, 1);
        rstb = 1'b0;
        adv(); cyc(1'b0);
        check("rst_mid_mem_write", bus_a.mem_write, 0);
        check("rst_mid_state", bus_a.state_dbg, S_FETCH);
        rstb = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
